// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction-cache refill engine: geometry defaults,
// RAM read latency and the refill FSM encoding.
package icache_refill_pkg;

   localparam int DEF_ADDR_WIDTH  = 17;
   localparam int DEF_BLOCK_WIDTH = 4;
   localparam int RD_LATENCY      = 1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_FETCH = 1'b1
   } refill_state_e;

endpackage

// File: rtl/icache_refill_if.sv
// Cache-request, RAM and cache-fill signals of the refill engine.
// The master side is the cache/RAM environment; the slave side is the engine.
interface icache_refill_if
   import icache_refill_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) ();

   localparam int BLOCK_SIZE = 2**BLOCK_WIDTH;

   logic                          missIn;
   logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] missAddrIn;
   logic [7:0]                    memReadData;
   logic [ADDR_WIDTH-1:0]         ramAddrOut;
   logic                          ramWriteOut;
   logic                          busyOut;
   logic                          blockValidOut;
   logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] blockAddrOut;
   logic [BLOCK_SIZE*8-1:0]       blockDataOut;

   modport master (
      output missIn, missAddrIn, memReadData,
      input  ramAddrOut, ramWriteOut, busyOut, blockValidOut, blockAddrOut, blockDataOut
   );

   modport slave (
      input  missIn, missAddrIn, memReadData,
      output ramAddrOut, ramWriteOut, busyOut, blockValidOut, blockAddrOut, blockDataOut
   );

endinterface

// File: rtl/icache_refill.sv
// Refill engine: fetches a block byte-by-byte from RAM, assembles it little-endian
// and hands it to the cache with a single-cycle valid pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a miss; last block held on the fill outputs
// S_FETCH | issuing byte addresses and capturing returned bytes
module icache_refill
   import icache_refill_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH
) (
   input logic             clkIn,
   input logic             resetIn,
   icache_refill_if.slave  bus
);

   localparam int BLOCK_SIZE = 2**BLOCK_WIDTH;
   localparam int TAG_W      = ADDR_WIDTH - BLOCK_WIDTH;
   localparam int CNT_W      = BLOCK_WIDTH + 1;

   refill_state_e           state_q, state_d;
   logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]        rcv_cnt_q, rcv_cnt_d;
   logic [RD_LATENCY:0]     rd_pipe_q, rd_pipe_d;
   logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
   logic                    busy_q, busy_d;
   logic                    blk_valid_q, blk_valid_d;
   logic [TAG_W-1:0]        blk_addr_q, blk_addr_d;
   logic [BLOCK_SIZE*8-1:0] blk_data_q, blk_data_d;

   // rd_pipe bit 0 marks a fresh address on the RAM port this cycle; the top bit
   // marks that memReadData carries the byte for an address issued earlier.
   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      rcv_cnt_d   = rcv_cnt_q;
      rd_pipe_d   = rd_pipe_q << 1;
      rd_pipe_d[0] = 1'b0;
      ram_addr_d  = ram_addr_q;
      busy_d      = busy_q;
      blk_valid_d = 1'b0;
      blk_addr_d  = blk_addr_q;
      blk_data_d  = blk_data_q;

      case (state_q)
         S_IDLE: begin
            if (bus.missIn && !blk_valid_q) begin
               state_d      = S_FETCH;
               blk_addr_d   = bus.missAddrIn;
               ram_addr_d   = {bus.missAddrIn, {BLOCK_WIDTH{1'b0}}};
               issue_cnt_d  = CNT_W'(1);
               rcv_cnt_d    = '0;
               busy_d       = 1'b1;
               rd_pipe_d[0] = 1'b1;
            end
         end
         S_FETCH: begin
            if (issue_cnt_q < CNT_W'(BLOCK_SIZE)) begin
               ram_addr_d   = {blk_addr_q, issue_cnt_q[BLOCK_WIDTH-1:0]};
               issue_cnt_d  = issue_cnt_q + CNT_W'(1);
               rd_pipe_d[0] = 1'b1;
            end
            if (rd_pipe_q[RD_LATENCY]) begin
               blk_data_d[{rcv_cnt_q[BLOCK_WIDTH-1:0], 3'b000} +: 8] = bus.memReadData;
               rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
               if (rcv_cnt_q == CNT_W'(BLOCK_SIZE - 1)) begin
                  state_d     = S_IDLE;
                  blk_valid_d = 1'b1;
                  busy_d      = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clkIn) begin
      if (resetIn) begin
         state_q     <= S_IDLE;
         issue_cnt_q <= '0;
         rcv_cnt_q   <= '0;
         rd_pipe_q   <= '0;
         ram_addr_q  <= '0;
         busy_q      <= 1'b0;
         blk_valid_q <= 1'b0;
         blk_addr_q  <= '0;
         blk_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         rcv_cnt_q   <= rcv_cnt_d;
         rd_pipe_q   <= rd_pipe_d;
         ram_addr_q  <= ram_addr_d;
         busy_q      <= busy_d;
         blk_valid_q <= blk_valid_d;
         blk_addr_q  <= blk_addr_d;
         blk_data_q  <= blk_data_d;
      end
   end

   assign bus.ramAddrOut    = ram_addr_q;
   assign bus.ramWriteOut   = 1'b0;
   assign bus.busyOut       = busy_q;
   assign bus.blockValidOut = blk_valid_q;
   assign bus.blockAddrOut  = blk_addr_q;
   assign bus.blockDataOut  = blk_data_q;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: RAM model returns byte = address[7:0];
// expected blocks are queued when a miss is issued and checked on each valid pulse.
module tb_icache_refill;

   logic clkIn = 1'b0;
   logic resetIn;

   icache_refill_if #(.ADDR_WIDTH(17), .BLOCK_WIDTH(4)) bus ();

   icache_refill dut (
      .clkIn   (clkIn),
      .resetIn (resetIn),
      .bus     (bus)
   );

   always #5 clkIn = ~clkIn;

   // RAM with one cycle of read latency
   always @(posedge clkIn) bus.memReadData <= bus.ramAddrOut[7:0];

   typedef struct {
      logic [12:0]  addr;
      logic [127:0] data;
   } blk_t;

   blk_t sb[$];
   int   pulse_cyc[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clkIn) cyc++;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] exp_data(input logic [12:0] a);
      logic [127:0] d;
      d = '0;
      for (int k = 0; k < 16; k++) d[8*k +: 8] = {a[3:0], 4'(k)};
      return d;
   endfunction

   task automatic sb_push(input logic [12:0] a);
      blk_t e;
      e.addr = a;
      e.data = exp_data(a);
      sb.push_back(e);
   endtask

   // Scoreboard side: every valid pulse must match the oldest queued block
   always @(negedge clkIn) begin
      if (!resetIn && bus.blockValidOut === 1'b1) begin
         pulse_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", bus.blockValidOut, 1'b0);
         end else begin
            blk_t e;
            e = sb.pop_front();
            chk("blk_addr", bus.blockAddrOut, e.addr);
            chk("blk_data", bus.blockDataOut, e.data);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clkIn);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ramaddr"}, bus.ramAddrOut, 0);
      chk({tag, "_ramwr"},   bus.ramWriteOut, 0);
      chk({tag, "_busy"},    bus.busyOut, 0);
      chk({tag, "_valid"},   bus.blockValidOut, 0);
      chk({tag, "_baddr"},   bus.blockAddrOut, 0);
      chk({tag, "_bdata"},   bus.blockDataOut, 0);
   endtask

   // Checks cycles n_from..n_to of a refill of block a; entered at the start of cycle n_from.
   task automatic run_fetch(input logic [12:0] a, input int n_from, input int n_to,
                            input int chg_n, input logic [12:0] chg_a);
      for (int n = n_from; n <= n_to; n++) begin
         if (n == chg_n) bus.missAddrIn = chg_a;
         @(negedge clkIn);
         if (n <= 16) chk("ram_addr", bus.ramAddrOut, {a, 4'(n - 1)});
         else         chk("ram_addr_hold", bus.ramAddrOut, {a, 4'hF});
         chk("busy", bus.busyOut, (n <= 17));
         chk("valid", bus.blockValidOut, (n == 18));
         chk("ram_wr", bus.ramWriteOut, 0);
         next_cycle();
      end
   endtask

   task automatic do_refill(input logic [12:0] a, input int chg_n, input logic [12:0] chg_a);
      sb_push(a);
      bus.missIn     = 1'b1;
      bus.missAddrIn = a;
      @(negedge clkIn);
      chk("accept_busy", bus.busyOut, 0);
      next_cycle();
      bus.missIn = 1'b0;
      run_fetch(a, 1, 18, chg_n, chg_a);
   endtask

   initial begin
      bus.missIn     = 1'b0;
      bus.missAddrIn = '0;
      resetIn        = 1'b1;

      // reset and idle
      next_cycle();
      @(negedge clkIn);
      chk_all_zero("in_reset");
      next_cycle();
      resetIn = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clkIn);
         chk_all_zero("idle");
         next_cycle();
      end

      // basic refill and hold of the delivered block
      do_refill(13'h0123, 0, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clkIn);
         chk("hold_data", bus.blockDataOut, 128'h3F3E3D3C3B3A39383736353433323130);
         chk("hold_addr", bus.blockAddrOut, 13'h0123);
         chk("hold_valid", bus.blockValidOut, 0);
         next_cycle();
      end

      // back-to-back misses with missIn held high
      sb_push(13'h0005);
      sb_push(13'h0006);
      bus.missIn     = 1'b1;
      bus.missAddrIn = 13'h0005;
      next_cycle();
      bus.missAddrIn = 13'h0006;
      run_fetch(13'h0005, 1, 18, 0, '0);
      @(negedge clkIn);
      chk("b2b_c19_busy", bus.busyOut, 0);
      chk("b2b_c19_addr", bus.ramAddrOut, 17'h0005F);
      next_cycle();
      run_fetch(13'h0006, 1, 18, 0, '0);
      bus.missIn = 1'b0;
      chk("b2b_pulse_gap", 128'(pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2]), 19);
      repeat (3) next_cycle();

      // missAddrIn changes mid-refill
      do_refill(13'h0040, 5, 13'h1FFF);
      bus.missAddrIn = '0;
      repeat (2) next_cycle();

      // reset in cycle 9 aborts the refill
      bus.missIn     = 1'b1;
      bus.missAddrIn = 13'h0077;
      next_cycle();
      bus.missIn = 1'b0;
      repeat (8) next_cycle();
      resetIn = 1'b1;
      next_cycle();
      @(negedge clkIn);
      chk_all_zero("abort");
      resetIn = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clkIn);
         chk("abort_no_valid", bus.blockValidOut, 0);
         chk("abort_no_busy", bus.busyOut, 0);
         next_cycle();
      end
      do_refill(13'h0099, 0, '0);

      // top block, no wrap
      do_refill(13'h1FFF, 0, '0);
      repeat (3) next_cycle();

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
